bayer_mosaic_streamer: RTL and testbench

- Inverse companion of the demosaic engine.
- Reads the three 128x128 R/G/B frame memories the demosaic engine writes.
- Emits a raster-order single-channel Bayer stream, one byte per pixel, with valid/ready flow control.
- Used to re-mosaic reconstructed frames for loopback checks and for driving the demosaic input from stored RGB images.

---
 rtl/bayer_mosaic_streamer.sv | 195 +++++++++++++++++++
 tb/tb_bayer_mosaic_streamer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_mosaic_streamer.sv
// Reads the R/G/B frame memories in raster order and streams one Bayer byte per pixel.
// Ports:
//   clk, reset (async active-high), start
//   wr_*/addr_*/wdata_* : memory ports (read-only use)
//   rdata_*             : 1-cycle synchronous read data
//   out_en/data_out/out_ready : valid/ready output stream
//   busy, done          : frame status
module bayer_mosaic_streamer #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128,
    parameter int AW     = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          wr_r,
    output logic          wr_g,
    output logic          wr_b,
    output logic [AW-1:0] addr_r,
    output logic [AW-1:0] addr_g,
    output logic [AW-1:0] addr_b,
    output logic [7:0]    wdata_r,
    output logic [7:0]    wdata_g,
    output logic [7:0]    wdata_b,
    input  logic [7:0]    rdata_r,
    input  logic [7:0]    rdata_g,
    input  logic [7:0]    rdata_b,
    output logic          out_en,
    output logic [7:0]    data_out,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [AW-1:0] PENULT = AW'(WIDTH * HEIGHT - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state, state_nx;

    logic [AW-1:0] addr;
    logic          av;
    logic          rv;
    logic [1:0]    rsel;
    logic [7:0]    sk0, sk1;
    logic [1:0]    sc;

    logic [7:0]    pix;
    logic          pop;
    logic          load;
    logic          start_go;
    logic          issue;
    logic          last_xfer;
    logic [2:0]    occ;
    logic [2:0]    occ_left;

    logic          out_en_nx;
    logic [7:0]    data_nx;
    logic [7:0]    sk0_nx, sk1_nx;
    logic [1:0]    sc_nx;

    assign wr_r    = 1'b0;
    assign wr_g    = 1'b0;
    assign wr_b    = 1'b0;
    assign wdata_r = 8'h00;
    assign wdata_g = 8'h00;
    assign wdata_b = 8'h00;
    assign addr_r  = addr;
    assign addr_g  = addr;
    assign addr_b  = addr;

    assign pop      = out_en & out_ready;
    assign load     = ~out_en | pop;
    assign start_go = (state == S_IDLE) & start;

    // Pixels held in the output register, skid store, returning read
    // and the read being addressed. Capped at 3 so a full stall always
    // fits in output + 2-entry skid.
    assign occ      = {2'b00, out_en} + {1'b0, sc} + {2'b00, rv} + {2'b00, av};
    assign occ_left = occ - {2'b00, pop};
    assign issue    = (state == S_FETCH) & (occ_left < 3'd3);

    // Nothing addressed in DRAIN, so an empty pipe behind a pop
    // means the frame's last pixel is leaving.
    assign last_xfer = (state == S_DRAIN) & pop & (sc == 2'd0) & ~rv & ~av;

    // Bayer pattern on {row lsb, col lsb} of the address that produced rdata
    always_comb begin
        pix = rdata_g;
        unique case (rsel)
            2'b00: pix = rdata_g;
            2'b01: pix = rdata_r;
            2'b10: pix = rdata_b;
            2'b11: pix = rdata_g;
            default: pix = rdata_g;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: if (issue && addr == PENULT) state_nx = S_DRAIN;
            S_DRAIN: if (last_xfer) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_FIN);
    end

    // Output register refills from the skid head first to keep order;
    // returning data goes behind whatever is already queued.
    always_comb begin
        out_en_nx = out_en;
        data_nx   = data_out;
        sk0_nx    = sk0;
        sk1_nx    = sk1;
        sc_nx     = sc;
        if (load) begin
            if (sc != 2'd0) begin
                out_en_nx = 1'b1;
                data_nx   = sk0;
                sk0_nx    = sk1;
                if (rv) begin
                    if (sc == 2'd1) begin
                        sk0_nx = pix;
                    end else begin
                        sk1_nx = pix;
                    end
                end else begin
                    sc_nx = sc - 2'd1;
                end
            end else if (rv) begin
                out_en_nx = 1'b1;
                data_nx   = pix;
            end else begin
                out_en_nx = 1'b0;
            end
        end else if (rv) begin
            if (sc == 2'd0) begin
                sk0_nx = pix;
            end else begin
                sk1_nx = pix;
            end
            sc_nx = sc + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr     <= '0;
            av       <= 1'b0;
            rv       <= 1'b0;
            rsel     <= 2'b00;
            out_en   <= 1'b0;
            data_out <= 8'h00;
            sk0      <= 8'h00;
            sk1      <= 8'h00;
            sc       <= 2'd0;
        end else begin
            if (start_go) begin
                addr <= '0;
            end else if (issue) begin
                addr <= addr + AW'(1);
            end
            av       <= start_go | issue;
            rv       <= av;
            rsel     <= {addr[CW], addr[0]};
            out_en   <= out_en_nx;
            data_out <= data_nx;
            sk0      <= sk0_nx;
            sk1      <= sk1_nx;
            sc       <= sc_nx;
        end
    end

endmodule

// File: tb/tb_bayer_mosaic_streamer.sv
// Self-checking bench for bayer_mosaic_streamer.
// Memory model plus a pattern-level reference of the expected Bayer stream.
module tb_bayer_mosaic_streamer;

    localparam int W     = 128;
    localparam int H     = 128;
    localparam int AW    = 14;
    localparam int N     = W * H;
    localparam int LIMIT = 60000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          wr_r, wr_g, wr_b;
    logic [AW-1:0] addr_r, addr_g, addr_b;
    logic [7:0]    wdata_r, wdata_g, wdata_b;
    logic [7:0]    rdata_r = 8'h00;
    logic [7:0]    rdata_g = 8'h00;
    logic [7:0]    rdata_b = 8'h00;
    logic          out_en;
    logic [7:0]    data_out;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;

    logic [7:0] mem_r [N];
    logic [7:0] mem_g [N];
    logic [7:0] mem_b [N];

    logic [7:0] got[$];
    int         xk[$];
    logic [7:0] prev_frame[$];

    int nx, ndone, unstable, ahead_max, lat, wr_bad;
    bit done_ok, busy_after, tout;

    bayer_mosaic_streamer #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
        .addr_r(addr_r), .addr_g(addr_g), .addr_b(addr_b),
        .wdata_r(wdata_r), .wdata_g(wdata_g), .wdata_b(wdata_b),
        .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b),
        .out_en(out_en), .data_out(data_out), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rdata_r <= mem_r[addr_r];
        rdata_g <= mem_g[addr_g];
        rdata_b <= mem_b[addr_b];
    end

    function automatic logic [7:0] model(input int p);
        logic [7:0] a;
        int r, c;
        a = p[7:0];
        r = p / W;
        c = p % W;
        if ((r % 2) == 0 && (c % 2) == 1) return a;
        if ((r % 2) == 1 && (c % 2) == 0) return a ^ 8'h5A;
        return ~a;
    endfunction

    function automatic int model_errs();
        int e;
        e = (got.size() == N) ? 0 : 1;
        foreach (got[i]) if (got[i] !== model(i)) e++;
        return e;
    endfunction

    function automatic logic [7:0] gp(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // mode 0: ready always 1, 1: random 50%, 2: ready low 100 cycles at pixel 5
    task automatic run_frame(input int mode, input bit mid_start, input bit start_at_done);
        int k, n, scnt, done_k, ahead;
        bit pstall, pxfer, mid_used, xfer;
        logic [7:0] pd;
        k = 0; n = 0; scnt = 0; done_k = -1;
        pstall = 0; pxfer = 0; mid_used = 0; pd = 8'h00;
        got.delete(); xk.delete();
        ndone = 0; unstable = 0; ahead_max = 0; lat = -1; wr_bad = 0;
        done_ok = 0; busy_after = 1; tout = 0;
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        forever begin
            if (out_en === 1'b1 && lat < 0) lat = k;
            if (wr_r || wr_g || wr_b || wdata_r != 0 || wdata_g != 0 || wdata_b != 0) wr_bad++;
            if (pstall && (out_en !== 1'b1 || data_out !== pd)) unstable++;
            if (busy === 1'b1) begin
                ahead = int'(addr_r) + 1 - (n + int'(out_en));
                if (ahead > ahead_max) ahead_max = ahead;
            end
            if (done === 1'b1) begin
                ndone++;
                if (done_k < 0) begin
                    done_k = k;
                    done_ok = pxfer && (n == N);
                end
            end
            if (done_k >= 0 && k == done_k + 1) begin
                busy_after = busy;
                start = 1'b0;
                break;
            end
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    out_ready = !(n == 5 && scnt < 100);
                    if (!out_ready) scnt++;
                end
                default: out_ready = 1'b1;
            endcase
            start = 1'b0;
            if (mid_start && n == 300 && !mid_used) begin
                start = 1'b1;
                mid_used = 1;
            end
            if (start_at_done && done === 1'b1) start = 1'b1;
            xfer = (out_en === 1'b1) && out_ready;
            if (xfer) begin
                got.push_back(data_out);
                xk.push_back(k);
                n++;
            end
            pstall = (out_en === 1'b1) && !out_ready;
            pd = data_out;
            pxfer = xfer;
            tick();
            k++;
            if (k > LIMIT) begin
                tout = 1;
                start = 1'b0;
                break;
            end
        end
        nx = n;
    endtask

    task automatic test_reset();
        total++; if (out_en !== 1'b0) begin bad++; $display("FAIL reset_out_en: got %b want 0", out_en); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (addr_r !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", addr_r); end
        reset = 1'b0;
        tick();
        tick();
        total++; if (busy !== 1'b0 || out_en !== 1'b0) begin
            bad++; $display("FAIL idle_quiet: busy=%b out_en=%b want 0 0", busy, out_en);
        end
    endtask

    task automatic test_basic();
        run_frame(0, 0, 1);
        total++; if (tout) begin bad++; $display("FAIL basic_timeout: got %0d transfers want %0d", nx, N); end
        total++; if (lat != 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", lat); end
        total++; if (nx != N) begin bad++; $display("FAIL basic_count: got %0d want %0d", nx, N); end
        total++; if (model_errs() != 0) begin bad++; $display("FAIL basic_stream: got %0d bad pixels want 0", model_errs()); end
        total++; if (gp(0) !== 8'hFF) begin bad++; $display("FAIL basic_px0: got %h want ff", gp(0)); end
        total++; if (gp(1) !== 8'h01) begin bad++; $display("FAIL basic_px1: got %h want 01", gp(1)); end
        total++; if (gp(128) !== 8'hDA) begin bad++; $display("FAIL basic_px128: got %h want da", gp(128)); end
        total++; if (gp(129) !== 8'h7E) begin bad++; $display("FAIL basic_px129: got %h want 7e", gp(129)); end
        total++; if (gp(N-1) !== 8'h00) begin bad++; $display("FAIL basic_pxlast: got %h want 00", gp(N-1)); end
        total++; if (ndone != 1 || !done_ok) begin
            bad++; $display("FAIL basic_done: pulses=%0d after_last=%0d want 1 1", ndone, done_ok);
        end
        total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy_fall: got %b want 0", busy_after); end
        total++; if (xk.size() == N ? (xk[N-1] - xk[0] != N - 1) : 1'b1) begin
            bad++; $display("FAIL basic_no_bubble: got span %0d want %0d", xk.size() == N ? xk[N-1] - xk[0] : -1, N - 1);
        end
        total++; if (wr_bad != 0) begin bad++; $display("FAIL basic_wr_zero: got %0d cycles want 0", wr_bad); end
        prev_frame = got;
    endtask

    task automatic test_random_ready();
        int diff;
        run_frame(1, 1, 0);
        diff = (got.size() == prev_frame.size()) ? 0 : 1;
        foreach (got[i]) if (i < prev_frame.size() && got[i] !== prev_frame[i]) diff++;
        total++; if (tout) begin bad++; $display("FAIL rand_timeout: got %0d transfers want %0d", nx, N); end
        total++; if (nx != N) begin bad++; $display("FAIL rand_count: got %0d want %0d", nx, N); end
        total++; if (model_errs() != 0) begin bad++; $display("FAIL rand_stream: got %0d bad pixels want 0", model_errs()); end
        total++; if (diff != 0) begin bad++; $display("FAIL rand_vs_first: got %0d diffs want 0", diff); end
        total++; if (unstable != 0) begin bad++; $display("FAIL rand_hold: got %0d unstable stalls want 0", unstable); end
        total++; if (ahead_max > 2) begin bad++; $display("FAIL rand_ahead: got %0d want <=2", ahead_max); end
        total++; if (ndone != 1 || !done_ok) begin
            bad++; $display("FAIL rand_done: pulses=%0d after_last=%0d want 1 1", ndone, done_ok);
        end
    endtask

    task automatic test_reset_mid();
        int n, k;
        n = 0; k = 0;
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        while (n < 1000 && k < 5000) begin
            if (out_en === 1'b1) n++;
            tick();
            k++;
        end
        total++; if (n != 1000) begin bad++; $display("FAIL mid_progress: got %0d want 1000", n); end
        reset = 1'b1;
        #1;
        total++; if (out_en !== 1'b0 || data_out !== 8'h00) begin
            bad++; $display("FAIL mid_reset_out: out_en=%b data=%h want 0 00", out_en, data_out);
        end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mid_reset_status: busy=%b done=%b want 0 0", busy, done);
        end
        total++; if (addr_r !== '0 || addr_g !== '0 || addr_b !== '0) begin
            bad++; $display("FAIL mid_reset_addr: got %0d %0d %0d want 0", addr_r, addr_g, addr_b);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        run_frame(2, 0, 0);
        total++; if (tout) begin bad++; $display("FAIL stall_timeout: got %0d transfers want %0d", nx, N); end
        total++; if (lat != 2 || gp(0) !== 8'hFF) begin
            bad++; $display("FAIL restart_px0: lat=%0d px=%h want 2 ff", lat, gp(0));
        end
        total++; if (nx != N) begin bad++; $display("FAIL stall_count: got %0d want %0d", nx, N); end
        total++; if (model_errs() != 0) begin bad++; $display("FAIL stall_stream: got %0d bad pixels want 0", model_errs()); end
        total++; if (xk.size() > 20 ? (xk[5] - xk[4] != 101) : 1'b1) begin
            bad++; $display("FAIL stall_len: got %0d want 101", xk.size() > 20 ? xk[5] - xk[4] : -1);
        end
        total++; if (xk.size() > 20 ? (xk[20] - xk[5] != 15) : 1'b1) begin
            bad++; $display("FAIL stall_no_gap: got %0d want 15", xk.size() > 20 ? xk[20] - xk[5] : -1);
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL stall_hold: got %0d want 0", unstable); end
        total++; if (ndone != 1 || !done_ok) begin
            bad++; $display("FAIL stall_done: pulses=%0d after_last=%0d want 1 1", ndone, done_ok);
        end
        prev_frame = got;
    endtask

    task automatic test_back_to_back();
        int diff;
        run_frame(0, 0, 0);
        diff = (got.size() == prev_frame.size()) ? 0 : 1;
        foreach (got[i]) if (i < prev_frame.size() && got[i] !== prev_frame[i]) diff++;
        total++; if (tout) begin bad++; $display("FAIL b2b_timeout: got %0d transfers want %0d", nx, N); end
        total++; if (lat != 2) begin bad++; $display("FAIL b2b_latency: got %0d want 2", lat); end
        total++; if (nx != N) begin bad++; $display("FAIL b2b_count: got %0d want %0d", nx, N); end
        total++; if (diff != 0) begin bad++; $display("FAIL b2b_match: got %0d diffs want 0", diff); end
        total++; if (ndone != 1 || !done_ok) begin
            bad++; $display("FAIL b2b_done: pulses=%0d after_last=%0d want 1 1", ndone, done_ok);
        end
        total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL b2b_busy_fall: got %b want 0", busy_after); end
        total++; if (wr_bad != 0) begin bad++; $display("FAIL b2b_wr_zero: got %0d cycles want 0", wr_bad); end
    endtask

    initial begin
        for (int a = 0; a < N; a++) begin
            logic [7:0] lo;
            lo = a[7:0];
            mem_r[a] = lo;
            mem_g[a] = ~lo;
            mem_b[a] = lo ^ 8'h5A;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_random_ready();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
